game_screen_ctrl: RTL and testbench
===================================

Name: game_screen_ctrl

Overview:
- Sequences the game's screens (start, play, end) and drives the screen-select, game-enable and game-reset signals consumed by the VGA draw pipeline and the game logic.
- Tracks frame boundaries from the timing counters and changes screens only at frame start, so no frame mixes two screens.
- Sits between the timing generator / mouse front-end and the per-screen draw blocks plus their output mux.

Parameters:
- END_HOLD_FRAMES, 120, frames the end screen is held before a click is accepted (1..1023)
- ARM_FRAMES, 2, consecutive frames start_btn must be low before a new press arms (1..15)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- hcount  in  11  horizontal counter from timing generator
- vcount  in  11  vertical counter from timing generator
- start_btn  in  1  mouse left button, already synchronised to clk
- game_over  in  1  one-cycle pulse from game logic, end of round
- game_result  in  2  result code, valid with game_over
- screen_sel  out  2  0=START, 1=PLAY, 2=END (3 never driven)
- game_en  out  1  high while the game is running
- game_rst  out  1  one-cycle pulse; game logic clears its state
- result  out  2  last latched game_result
- frame_tick  out  1  one-cycle pulse, first pixel of each frame

Behaviour:
- Reset (rst=0, async): state=START, screen_sel=0, game_en=0, game_rst=0, result=0, frame_tick=0, all counters 0, press_pending=0.
- frame_tick: registered; high the cycle after hcount==0 && vcount==0 are sampled (latency 1).
- Arming: arm_cnt counts frame_ticks while start_btn=0 and saturates at ARM_FRAMES. If start_btn=1 it is cleared. armed = (arm_cnt==ARM_FRAMES).
- Press detect: a rising edge of start_btn while armed sets press_pending and clears arm_cnt. press_pending is cleared on the cycle it is consumed, and on every screen change.
- FSM: all transitions occur only in the frame_tick cycle. Outputs are registered and update the cycle after the transition.
  - START -> PLAY when press_pending. game_rst pulses for exactly 1 cycle coincident with screen_sel becoming 1. game_en rises together with screen_sel.
  - PLAY: game_over pulses are latched immediately into over_pending, and game_result into result, at any cycle. PLAY -> END at the next frame_tick with over_pending=1; over_pending is then cleared and game_en drops. Button presses are ignored in PLAY (press_pending is forced 0).
  - END: hold_cnt (10 bit) clears on entry and increments per frame_tick, saturating at END_HOLD_FRAMES. Presses are ignored (press_pending forced 0) until saturation. END -> START on press_pending after saturation.
- Simultaneous events:
  - game_over in the same cycle as frame_tick: the transition happens at that tick.
  - A second game_over before the tick: the later result wins.
  - game_over outside PLAY is ignored and does not update result.
- result holds its value through START until the next valid game_over.
- A reset mid-frame returns to START immediately. The screen then stays START until a press, with arming fully re-qualified.

Optional Feature:
- Macro AUTO_RESTART_EN.
- Defined: in END, once hold_cnt saturates, the next frame_tick moves END -> START without a click, and a pending press is discarded.
- Undefined: END exits only on a qualified click, as described in Behaviour.

Decomposition:
- Add to vga_pkg:
  - typedef enum logic [1:0] screen_t {SCR_START=0, SCR_PLAY=1, SCR_END=2}, shared with the draw-output mux.
  - typedef logic [1:0] result_t with constants RES_LOSE=0, RES_WIN=1, RES_DRAW=2.
- One sub-module, btn_arm_detect: arm counter plus edge detect, output press pulse. The FSM, hold counter and frame_tick logic stay in game_screen_ctrl.

Test Plan:
- Reset then start_btn low for 2 frames, press at mid-frame -> screen_sel 0->1 one cycle after next frame_tick; game_rst high exactly 1 cycle; game_en=1.
- Button held high across reset release, then pressed again without low frames -> no transition. Low for 2 frames then press -> PLAY.
- In PLAY, game_over with game_result=1 at mid-frame -> result=1 immediately; screen_sel=2 and game_en=0 after next frame_tick. Presses in PLAY have no effect.
- END with END_HOLD_FRAMES=4: press at frame 2 -> stays END. Press after frame 4 -> START at following tick; result still 1.
- game_over coincident with frame_tick, and two game_over pulses (results 2 then 0) in one frame -> transition at that tick; result=0.
- AUTO_RESTART_EN defined, END_HOLD_FRAMES=4, no clicks -> START reached exactly 5 frame_ticks after END entry. rst=0 mid-frame in PLAY -> all outputs zero asynchronously.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA/game types: screen encoding used by the screen controller and
// the draw-output mux, plus the game result codes.
package vga_pkg;

    typedef enum logic [1:0] {
        SCR_START = 2'd0,
        SCR_PLAY  = 2'd1,
        SCR_END   = 2'd2
    } screen_t;

    typedef logic [1:0] result_t;

    localparam result_t RES_LOSE = 2'd0;
    localparam result_t RES_WIN  = 2'd1;
    localparam result_t RES_DRAW = 2'd2;

endpackage

// File: rtl/btn_arm_detect.sv
// Button arming and press detection.
// A press is only reported after the button has been seen low for ARM_FRAMES
// consecutive frame ticks, so a button held across a screen change or a
// reset cannot trigger the next screen by itself.
module btn_arm_detect #(
    parameter int ARM_FRAMES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_tick_i,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [3:0] ARM_MAX = 4'(ARM_FRAMES);

    logic [3:0] arm_cnt_q, arm_cnt_d;
    logic       btn_q;
    logic       armed;
    logic       rise;

    assign armed   = (arm_cnt_q == ARM_MAX);
    assign rise    = btn_i & ~btn_q;
    assign press_o = rise & armed;

    // Count low frames up to ARM_MAX; any high sample (including the press
    // itself) drops the arm count back to zero.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (btn_i) begin
            arm_cnt_d = '0;
        end else if (frame_tick_i && !armed) begin
            arm_cnt_d = arm_cnt_q + 4'd1;
        end
    end

    // Arm counter and previous button sample for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arm_cnt_q <= '0;
            btn_q     <= 1'b0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
            btn_q     <= btn_i;
        end
    end

endmodule

// File: rtl/game_screen_ctrl.sv
// Game screen sequencer: START -> PLAY -> END -> START.
// Screen changes happen only in the frame_tick cycle so a frame never mixes
// two screens. screen_sel is the state register itself, so the FSM state is
// directly observable on that output.
// Optional build macro AUTO_RESTART_EN: when defined, END returns to START on
// its own once the hold time has elapsed instead of waiting for a click.
module game_screen_ctrl
    import vga_pkg::*;
#(
    parameter int END_HOLD_FRAMES = 120,
    parameter int ARM_FRAMES      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        start_btn,
    input  logic        game_over,
    input  logic [1:0]  game_result,
    output logic [1:0]  screen_sel,
    output logic        game_en,
    output logic        game_rst,
    output logic [1:0]  result,
    output logic        frame_tick
);

    localparam logic [1:0] ST_START = SCR_START;
    localparam logic [1:0] ST_PLAY  = SCR_PLAY;
    localparam logic [1:0] ST_END   = SCR_END;
    localparam logic [9:0] HOLD_MAX = 10'(END_HOLD_FRAMES);

    logic [1:0] state_q, state_d;
    logic       frame_tick_q, frame_tick_d;
    logic       game_en_q, game_en_d;
    logic       game_rst_q, game_rst_d;
    result_t    result_q, result_d;
    logic       over_pending_q, over_pending_d;
    logic       press_pending_q, press_pending_d;
    logic [9:0] hold_cnt_q, hold_cnt_d;
    logic       press;
    logic       hold_sat;

    btn_arm_detect #(
        .ARM_FRAMES(ARM_FRAMES)
    ) u_btn_arm_detect (
        .clk_i        (clk),
        .rst_ni       (rst),
        .frame_tick_i (frame_tick_q),
        .btn_i        (start_btn),
        .press_o      (press)
    );

    assign frame_tick_d = (hcount == 11'd0) && (vcount == 11'd0);
    assign hold_sat     = (hold_cnt_q == HOLD_MAX);

    // Next-state logic: pending flags, hold counter, result latch and the
    // screen transitions, which are all gated by frame_tick_q.
    always_comb begin
        state_d         = state_q;
        over_pending_d  = over_pending_q;
        press_pending_d = press_pending_q;
        hold_cnt_d      = hold_cnt_q;
        result_d        = result_q;
        game_rst_d      = 1'b0;
        case (state_q)
            ST_START: begin
                hold_cnt_d = '0;
                if (press) begin
                    press_pending_d = 1'b1;
                end
                if (frame_tick_q && press_pending_q) begin
                    state_d         = ST_PLAY;
                    press_pending_d = 1'b0;
                    game_rst_d      = 1'b1;
                end
            end
            ST_PLAY: begin
                hold_cnt_d      = '0;
                press_pending_d = 1'b0;
                if (game_over) begin
                    over_pending_d = 1'b1;
                    result_d       = game_result;
                end
                // A game_over landing on the tick itself ends the round now.
                if (frame_tick_q && (over_pending_q || game_over)) begin
                    state_d        = ST_END;
                    over_pending_d = 1'b0;
                end
            end
            ST_END: begin
                if (!hold_sat) begin
                    press_pending_d = 1'b0;
                end else if (press) begin
                    press_pending_d = 1'b1;
                end
                if (frame_tick_q && !hold_sat) begin
                    hold_cnt_d = hold_cnt_q + 10'd1;
                end
`ifdef AUTO_RESTART_EN
                if (frame_tick_q && hold_sat) begin
                    state_d         = ST_START;
                    press_pending_d = 1'b0;
                    hold_cnt_d      = '0;
                end
`else
                if (frame_tick_q && hold_sat && press_pending_q) begin
                    state_d         = ST_START;
                    press_pending_d = 1'b0;
                    hold_cnt_d      = '0;
                end
`endif
            end
            default: begin
                state_d         = ST_START;
                over_pending_d  = 1'b0;
                press_pending_d = 1'b0;
                hold_cnt_d      = '0;
            end
        endcase
        game_en_d = (state_d == ST_PLAY);
    end

    // State and registered outputs; async reset returns to a clean START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_START;
            frame_tick_q    <= 1'b0;
            game_en_q       <= 1'b0;
            game_rst_q      <= 1'b0;
            result_q        <= RES_LOSE;
            over_pending_q  <= 1'b0;
            press_pending_q <= 1'b0;
            hold_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            frame_tick_q    <= frame_tick_d;
            game_en_q       <= game_en_d;
            game_rst_q      <= game_rst_d;
            result_q        <= result_d;
            over_pending_q  <= over_pending_d;
            press_pending_q <= press_pending_d;
            hold_cnt_q      <= hold_cnt_d;
        end
    end

    assign screen_sel = state_q;
    assign game_en    = game_en_q;
    assign game_rst   = game_rst_q;
    assign result     = result_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl with a shrunken 16x8 raster so a frame
// is 128 clocks. Inputs change on the falling edge; outputs are sampled on
// the falling edge, away from the rising (active) edge.
module tb_game_screen_ctrl;

    localparam int H_TOTAL = 16;
    localparam int V_TOTAL = 8;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        start_btn;
    logic        game_over;
    logic [1:0]  game_result;
    logic [1:0]  screen_sel;
    logic        game_en;
    logic        game_rst;
    logic [1:0]  result;
    logic        frame_tick;

    int checks;
    int failures;

    game_screen_ctrl #(
        .END_HOLD_FRAMES(4),
        .ARM_FRAMES     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .start_btn  (start_btn),
        .game_over  (game_over),
        .game_result(game_result),
        .screen_sel (screen_sel),
        .game_en    (game_en),
        .game_rst   (game_rst),
        .result     (result),
        .frame_tick (frame_tick)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running raster counters, independent of reset
    initial begin
        hcount = 11'd0;
        vcount = 11'd0;
        forever begin
            @(negedge clk);
            if (hcount == 11'(H_TOTAL - 1)) begin
                hcount = 11'd0;
                if (vcount == 11'(V_TOTAL - 1)) vcount = 11'd0;
                else vcount = vcount + 11'd1;
            end else begin
                hcount = hcount + 11'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the falling edge inside the next frame_tick cycle.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 400);
        checks++;
        assert (frame_tick === 1'b1) else begin
            failures++;
            $error("FAIL %s: frame_tick observed=0 expected=1 within %0d cycles", tag, n);
        end
    endtask

    task automatic press_btn();
        start_btn = 1'b1;
        step(3);
        start_btn = 1'b0;
    endtask

    task automatic pulse_over(input logic [1:0] res);
        game_over   = 1'b1;
        game_result = res;
        step(1);
        game_over   = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        start_btn   = 1'b0;
        game_over   = 1'b0;
        game_result = 2'd0;

        // ---- reset state
        step(3);
        chk("rst_sel", 32'(screen_sel), 0);
        chk("rst_en", 32'(game_en), 0);
        chk("rst_grst", 32'(game_rst), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        rst = 1'b1;

        // ---- 1: arm for two frames, press mid-frame, enter PLAY
        wait_tick("t1_arm1");
        wait_tick("t1_arm2");
        step(20);
        press_btn();
        step(2);
        chk("t1_sel_before_tick", 32'(screen_sel), 0);
        wait_tick("t1_go");
        chk("t1_sel_in_tick", 32'(screen_sel), 0);
        step(1);
        chk("t1_sel_play", 32'(screen_sel), 1);
        chk("t1_grst_high", 32'(game_rst), 1);
        chk("t1_en_high", 32'(game_en), 1);
        step(1);
        chk("t1_grst_low", 32'(game_rst), 0);
        chk("t1_en_stays", 32'(game_en), 1);

        // ---- 2: button held through reset release, re-press without low frames
        start_btn = 1'b1;
        rst = 1'b0;
        #1;
        chk("t2_async_sel", 32'(screen_sel), 0);
        chk("t2_async_en", 32'(game_en), 0);
        step(3);
        rst = 1'b1;
        wait_tick("t2_held1");
        wait_tick("t2_held2");
        start_btn = 1'b0;
        step(3);
        press_btn();
        wait_tick("t2_nopress");
        step(1);
        chk("t2_no_transition", 32'(screen_sel), 0);
        chk("t2_no_grst", 32'(game_rst), 0);
        wait_tick("t2_arm1");
        wait_tick("t2_arm2");
        step(20);
        press_btn();
        wait_tick("t2_go");
        step(1);
        chk("t2_sel_play", 32'(screen_sel), 1);
        chk("t2_grst", 32'(game_rst), 1);

        // ---- 3: press ignored in PLAY, then game_over ends the round
        wait_tick("t3_arm1");
        wait_tick("t3_arm2");
        step(20);
        press_btn();
        wait_tick("t3_ign");
        step(1);
        chk("t3_press_ignored_sel", 32'(screen_sel), 1);
        chk("t3_press_ignored_en", 32'(game_en), 1);
        wait_tick("t3_rearm");
        step(20);
        pulse_over(2'd1);
        chk("t3_result_now", 32'(result), 1);
        chk("t3_still_play", 32'(screen_sel), 1);
        wait_tick("t3_end");
        step(1);
        chk("t3_sel_end", 32'(screen_sel), 2);
        chk("t3_en_low", 32'(game_en), 0);

        // ---- 4: END hold of 4 frames; early press ignored, late press accepted
        wait_tick("t4_h1");
        wait_tick("t4_h2");
        step(20);
        press_btn();
        wait_tick("t4_h3");
        step(1);
        chk("t4_early_press_ignored", 32'(screen_sel), 2);
        wait_tick("t4_h4");
        step(20);
        press_btn();
        wait_tick("t4_h5");
        step(1);
        chk("t4_sel_start", 32'(screen_sel), 0);
        chk("t4_result_held", 32'(result), 1);
        chk("t4_en_low", 32'(game_en), 0);

        // ---- 5a: game_over in START ignored; game_over on the tick itself
        step(10);
        pulse_over(2'd2);
        chk("t5_over_in_start_ignored", 32'(result), 1);
        wait_tick("t5_arm1");
        wait_tick("t5_arm2");
        step(20);
        press_btn();
        wait_tick("t5_go");
        step(1);
        chk("t5_sel_play", 32'(screen_sel), 1);
        wait_tick("t5_coincident");
        pulse_over(2'd2);
        chk("t5_coinc_sel_end", 32'(screen_sel), 2);
        chk("t5_coinc_result", 32'(result), 2);
        step(10);
        pulse_over(2'd0);
        chk("t5_over_in_end_ignored", 32'(result), 2);
        wait_tick("t5_h1");
        wait_tick("t5_h2");
        wait_tick("t5_h3");
        wait_tick("t5_h4");
        step(20);
        press_btn();
        wait_tick("t5_back");
        step(1);
        chk("t5_sel_start", 32'(screen_sel), 0);

        // ---- 5b: two game_over pulses in one frame, the later result wins
        wait_tick("t5b_arm1");
        wait_tick("t5b_arm2");
        step(20);
        press_btn();
        wait_tick("t5b_go");
        step(20);
        pulse_over(2'd2);
        step(5);
        pulse_over(2'd0);
        chk("t5b_result_later", 32'(result), 0);
        chk("t5b_still_play", 32'(screen_sel), 1);
        wait_tick("t5b_end");
        step(1);
        chk("t5b_sel_end", 32'(screen_sel), 2);
        chk("t5b_result", 32'(result), 0);

        // ---- 6: no clicks in END
        wait_tick("t6_h1");
        wait_tick("t6_h2");
        wait_tick("t6_h3");
        wait_tick("t6_h4");
        step(1);
        chk("t6_end_at_4", 32'(screen_sel), 2);
        wait_tick("t6_h5");
        step(1);
`ifdef AUTO_RESTART_EN
        chk("t6_auto_start", 32'(screen_sel), 0);
`else
        chk("t6_held_end", 32'(screen_sel), 2);
        step(20);
        press_btn();
        wait_tick("t6_click");
        step(1);
        chk("t6_click_start", 32'(screen_sel), 0);
`endif

        // ---- 7: reset mid-frame while in PLAY
        wait_tick("t7_arm1");
        wait_tick("t7_arm2");
        step(20);
        press_btn();
        wait_tick("t7_go");
        step(1);
        chk("t7_sel_play", 32'(screen_sel), 1);
        step(20);
        pulse_over(2'd1);
        chk("t7_result_pre", 32'(result), 1);
        step(5);
        rst = 1'b0;
        #1;
        chk("t7_async_sel", 32'(screen_sel), 0);
        chk("t7_async_en", 32'(game_en), 0);
        chk("t7_async_grst", 32'(game_rst), 0);
        chk("t7_async_result", 32'(result), 0);
        chk("t7_async_tick", 32'(frame_tick), 0);
        step(3);
        rst = 1'b1;
        wait_tick("t7_after1");
        step(1);
        chk("t7_stays_start", 32'(screen_sel), 0);
        chk("t7_en_low", 32'(game_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
